// File: rtl/adc_scan_pkg.sv
// ---------------------------------------------------------------------------
// adc_scan_pkg
//   Shared types, frame-format constants and channel-list helpers for the
//   ADC scan arbiter.
//   Contents:
//     state_e      arbiter / burst FSM states
//     FRAME_BITS   SCLK periods per ADC frame
//     ADDR_LSB_BIT first DIN bit (0-based, transmit order) carrying ADD2
//     DATA_LSB_BIT first DOUT bit (0-based, transmit order) carrying DB11
//     CH_W         channel index width
//     popcount8 / first_ch / next_ch / din_bit helpers
// ---------------------------------------------------------------------------
package adc_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST,
        CS_SETUP,
        SCLK_LO,
        SCLK_HI,
        CS_HOLD,
        GAP
    } state_e;

    localparam int FRAME_BITS   = 16;
    localparam int ADDR_LSB_BIT = 2;
    localparam int DATA_LSB_BIT = 4;
    localparam int CH_W         = 3;
    localparam int NCH_MAX      = 1 << CH_W;

    // Index of the last bit of a frame, in the bit counter's width.
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    // Number of channels selected by a mask (0..8).
    function automatic logic [3:0] popcount8(input logic [NCH_MAX-1:0] m);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < NCH_MAX; i++) begin
            cnt = cnt + {3'b000, m[i]};
        end
        return cnt;
    endfunction

    // Lowest selected channel; 0 for an empty mask.
    function automatic logic [CH_W-1:0] first_ch(input logic [NCH_MAX-1:0] m);
        logic [CH_W-1:0] r;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NCH_MAX; i++) begin
            if (m[i] && !found) begin
                r     = CH_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Next selected channel above cur, wrapping to the lowest one. The wrap
    // is what makes the final (dummy) frame re-address the first channel.
    function automatic logic [CH_W-1:0] next_ch(input logic [NCH_MAX-1:0] m,
                                                input logic [CH_W-1:0]    cur);
        logic [CH_W-1:0] r;
        logic            found;
        r     = first_ch(m);
        found = 1'b0;
        for (int i = 0; i < NCH_MAX; i++) begin
            if (m[i] && (CH_W'(i) > cur) && !found) begin
                r     = CH_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // DIN value for transmit position idx of a frame addressing ch:
    // ADD2..ADD0 sit at positions ADDR_LSB_BIT.., everything else is 0.
    function automatic logic din_bit(input logic [CH_W-1:0] ch,
                                     input logic [3:0]      idx);
        logic b;
        b = 1'b0;
        for (int k = 0; k < CH_W; k++) begin
            if (idx == 4'(ADDR_LSB_BIT + k)) begin
                b = ch[CH_W-1-k];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/adc_scan_arbiter_ff_sync.sv
// ---------------------------------------------------------------------------
// ff_sync
//   Two-stage synchroniser for a single asynchronous level.
//   Ports:
//     clk  in  destination clock
//     rst  in  synchronous reset, active-high; both stages load RST_VAL
//     d    in  asynchronous input
//     q    out synchronised output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module ff_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments let meta and q update together, so the
    // chain really is two flops; blocking here would collapse it into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_scan_arbiter.sv
// ---------------------------------------------------------------------------
// adc_scan_arbiter
//   Periodic burst scanner for an 8-channel 12-bit SPI ADC whose pins are
//   shared with an external host SPI bus. Bursts of M+1 frames run under a
//   single CS low; results are streamed out tagged with their channel. The
//   host only gets the pins while the scanner is idle.
//   Ports:
//     clk, rst                 system clock, synchronous active-high reset
//     en, ch_mask              scanner enable and channel selection (LSB=IN0)
//     host_sclk/mosi/ss_n      host SPI master pins (ss_n async to clk)
//     host_miso                ADC DOUT while granted, else high-impedance
//     host_grant               host currently owns the ADC pins
//     adc_sclk/mosi/ss_n       ADC pins (SCLK idles high)
//     adc_miso                 ADC DOUT
//     smp_valid/ch/data        one-cycle sample strobe with channel and value
//     busy                     burst in progress (CS_SETUP..CS_HOLD)
// ---------------------------------------------------------------------------
module adc_scan_arbiter
    import adc_scan_pkg::*;
#(
    parameter int SCLK_DIV = 25,
    parameter int SCAN_GAP = 5000,
    parameter int NCH      = 8,
    parameter int DATA_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH-1:0]    ch_mask,
    input  logic              host_sclk,
    input  logic              host_mosi,
    input  logic              host_ss_n,
    output wire logic         host_miso,
    output logic              host_grant,
    output logic              adc_sclk,
    output logic              adc_mosi,
    output logic              adc_ss_n,
    input  logic              adc_miso,
    output logic              smp_valid,
    output logic [CH_W-1:0]   smp_ch,
    output logic [DATA_W-1:0] smp_data,
    output logic              busy
);

    localparam int DIV_W = $clog2(SCLK_DIV + 1);
    localparam int GAP_W = $clog2(SCAN_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);

    state_e            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [3:0]        bit_cnt;
    logic [3:0]        frame_cnt;
    logic [3:0]        frame_last;   // M: index of the trailing dummy frame
    logic [GAP_W-1:0]  gap_cnt;
    logic [NCH-1:0]    mask_q;
    logic [CH_W-1:0]   cur_ch;       // channel addressed by the current frame
    logic [CH_W-1:0]   prev_ch;      // channel addressed by the previous frame
    logic [DATA_W-2:0] rx_sr;
    logic              sclk_q;
    logic              mosi_q;
    logic              ss_n_q;
    logic              hs_n;

    ff_sync #(.RST_VAL(1'b1)) u_host_ss_sync (
        .clk (clk),
        .rst (rst),
        .d   (host_ss_n),
        .q   (hs_n)
    );

    // Pin ownership follows the registered grant so it can only change in
    // IDLE/HOST, never inside a scanner burst.
    assign adc_sclk  = host_grant ? host_sclk : sclk_q;
    assign adc_mosi  = host_grant ? host_mosi : mosi_q;
    assign adc_ss_n  = host_grant ? host_ss_n : ss_n_q;
    assign host_miso = host_grant ? adc_miso  : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            frame_cnt  <= '0;
            frame_last <= '0;
            gap_cnt    <= '0;
            mask_q     <= '0;
            cur_ch     <= '0;
            prev_ch    <= '0;
            rx_sr      <= '0;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            host_grant <= 1'b0;
            busy       <= 1'b0;
            smp_valid  <= 1'b0;
            smp_ch     <= '0;
            smp_data   <= '0;
        end else begin
            smp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    // Host request wins over a scan request in the same cycle.
                    if (!hs_n) begin
                        state      <= HOST;
                        host_grant <= 1'b1;
                    end else if (en && (ch_mask != '0)) begin
                        // The burst works from this snapshot; later mask edits
                        // only affect the next burst.
                        state      <= CS_SETUP;
                        mask_q     <= ch_mask;
                        frame_last <= popcount8(ch_mask);
                        frame_cnt  <= '0;
                        cur_ch     <= first_ch(ch_mask);
                        prev_ch    <= first_ch(ch_mask);
                        div_cnt    <= '0;
                        ss_n_q     <= 1'b0;
                        sclk_q     <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                HOST: begin
                    if (hs_n) begin
                        state      <= IDLE;
                        host_grant <= 1'b0;
                    end
                end

                CS_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= SCLK_LO;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sclk_q  <= 1'b0;
                        mosi_q  <= din_bit(cur_ch, 4'd0);
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SCLK_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        // Rising SCLK: DOUT is captured on this same edge.
                        state   <= SCLK_HI;
                        div_cnt <= '0;
                        sclk_q  <= 1'b1;
                        rx_sr   <= {rx_sr[DATA_W-3:0], adc_miso};
                        // Frame 0 carries the result of a conversion nobody
                        // asked for; every later frame returns the channel
                        // addressed one frame earlier.
                        if ((bit_cnt == BIT_LAST) && (frame_cnt != '0)) begin
                            smp_valid <= 1'b1;
                            smp_ch    <= prev_ch;
                            smp_data  <= {rx_sr, adc_miso};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SCLK_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_cnt != BIT_LAST) begin
                            state   <= SCLK_LO;
                            bit_cnt <= bit_cnt + 1'b1;
                            sclk_q  <= 1'b0;
                            mosi_q  <= din_bit(cur_ch, bit_cnt + 1'b1);
                        end else if (frame_cnt != frame_last) begin
                            state     <= SCLK_LO;
                            frame_cnt <= frame_cnt + 1'b1;
                            bit_cnt   <= '0;
                            sclk_q    <= 1'b0;
                            prev_ch   <= cur_ch;
                            cur_ch    <= next_ch(mask_q, cur_ch);
                            mosi_q    <= 1'b0;   // position 0 never carries address
                        end else begin
                            state <= CS_HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                CS_HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                        ss_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_arbiter
//   Randomised bench for adc_scan_arbiter with a behavioural SPI ADC that
//   decodes the address from each 16-bit DIN frame and returns 12'hA00|ch of
//   the previously addressed channel in the next frame. Expected traffic is
//   derived from the channel mask alone.
// ---------------------------------------------------------------------------
module tb_adc_scan_arbiter;

    localparam int SCLK_DIV = 2;
    localparam int SCAN_GAP = 20;
    localparam int BUDGET   = 3000;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        en        = 1'b0;
    logic [7:0]  ch_mask   = 8'h00;
    logic        host_sclk = 1'b1;
    logic        host_mosi = 1'b0;
    logic        host_ss_n = 1'b1;
    wire         host_miso;
    logic        host_grant;
    logic        adc_sclk;
    logic        adc_mosi;
    logic        adc_ss_n;
    logic        adc_miso  = 1'b0;
    logic        smp_valid;
    logic [2:0]  smp_ch;
    logic [11:0] smp_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    adc_scan_arbiter #(
        .SCLK_DIV (SCLK_DIV),
        .SCAN_GAP (SCAN_GAP),
        .NCH      (8),
        .DATA_W   (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_mask    (ch_mask),
        .host_sclk  (host_sclk),
        .host_mosi  (host_mosi),
        .host_ss_n  (host_ss_n),
        .host_miso  (host_miso),
        .host_grant (host_grant),
        .adc_sclk   (adc_sclk),
        .adc_mosi   (adc_mosi),
        .adc_ss_n   (adc_ss_n),
        .adc_miso   (adc_miso),
        .smp_valid  (smp_valid),
        .smp_ch     (smp_ch),
        .smp_data   (smp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural ADC ----------------
    logic [15:0] out_word = 16'h0BAD;
    logic [15:0] din_word = 16'h0000;
    int          adc_bit  = 0;
    int          din_log[$];
    int          din_bad  = 0;

    always @(negedge adc_ss_n) begin
        adc_bit  = 0;
        din_word = '0;
        out_word = 16'h0BAD;
    end

    always @(negedge adc_sclk) begin
        if (adc_ss_n == 1'b0) adc_miso = out_word[15 - adc_bit];
    end

    always @(posedge adc_sclk) begin
        if (adc_ss_n == 1'b0) begin
            din_word = {din_word[14:0], adc_mosi};
            adc_bit++;
            if (adc_bit == 16) begin
                din_log.push_back(int'(din_word[13:11]));
                if ((din_word & 16'hC7FF) != 16'h0000) din_bad++;
                out_word = {4'h0, 12'hA00 | {9'b0, din_word[13:11]}};
                adc_bit  = 0;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [14:0] smp_q[$];
    int   cyc        = 0;
    int   rise_cyc   = 0;
    int   fall_cyc   = 0;
    int   dbl_cnt    = 0;
    int   busy_cyc   = 0;
    int   ss_low_cyc = 0;
    logic prev_valid = 1'b0;
    logic prev_ss    = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (smp_valid) smp_q.push_back({smp_ch, smp_data});
        if (smp_valid && prev_valid) dbl_cnt++;
        prev_valid = smp_valid;
        if (!host_grant && (adc_ss_n !== prev_ss)) begin
            if (adc_ss_n) rise_cyc = cyc;
            else          fall_cyc = cyc;
        end
        prev_ss = adc_ss_n;
        if (busy) busy_cyc++;
        if (!adc_ss_n && !host_grant) ss_low_cyc++;
    end

    // ---------------- sequencing helpers ----------------
    int smp_base = 0;
    int din_base = 0;
    int dbl_base = 0;

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, lvl);
    endtask

    task automatic start_burst(input logic [7:0] m, input bit chk_gap);
        ch_mask = m;
        en      = 1'b1;
        wait_busy(1'b1, "busy_rise");
        @(negedge clk);
        smp_base = smp_q.size();
        din_base = din_log.size();
        dbl_base = dbl_cnt;
        din_bad  = 0;
        if (chk_gap) check("scan_gap", (fall_cyc - rise_cyc) >= SCAN_GAP, 1'b1);
    endtask

    // Expected traffic from the mask alone: addresses are the set bits in
    // ascending order plus a repeat of the first, samples are one per set bit.
    task automatic compare_burst(input logic [7:0] m);
        int          exp_addr[$];
        logic [14:0] exp_smp[$];
        for (int ch = 0; ch < 8; ch++) begin
            if (m[ch]) begin
                exp_addr.push_back(ch);
                exp_smp.push_back({3'(ch), 12'hA00 | 12'(ch)});
            end
        end
        exp_addr.push_back(exp_addr[0]);
        check("n_frames", din_log.size() - din_base, exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (din_base + i < din_log.size())
                check("din_addr", din_log[din_base + i], exp_addr[i]);
        end
        check("din_zero_bits", din_bad, 0);
        check("n_samples", smp_q.size() - smp_base, exp_smp.size());
        for (int i = 0; i < exp_smp.size(); i++) begin
            if (smp_base + i < smp_q.size())
                check("sample", smp_q[smp_base + i], exp_smp[i]);
        end
        check("smp_pulse_1cyc", dbl_cnt - dbl_base, 0);
        check("end_ss_n", adc_ss_n, 1'b1);
        check("end_sclk", adc_sclk, 1'b1);
    endtask

    task automatic finish_burst(input logic [7:0] m, input logic [7:0] mid, input bit drop_en);
        repeat (5) @(negedge clk);
        ch_mask = mid;
        if (drop_en) en = 1'b0;
        wait_busy(1'b0, "busy_fall");
        compare_burst(m);
    endtask

    task automatic quiet_window(input string tag);
        int b0 = busy_cyc;
        int s0 = ss_low_cyc;
        repeat (200) @(negedge clk);
        check(tag, (busy_cyc - b0) + (ss_low_cyc - s0), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] m;
        int         lat;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_grant", host_grant, 1'b0);
        check("rst_ss_n",  adc_ss_n,   1'b1);
        check("rst_sclk",  adc_sclk,   1'b1);
        check("rst_mosi",  adc_mosi,   1'b0);
        check("rst_valid", smp_valid,  1'b0);
        check("rst_ch",    smp_ch,     3'd0);
        check("rst_data",  smp_data,   12'd0);
        check("rst_busy",  busy,       1'b0);
        check("rst_miso_z", host_miso === 1'bz, 1'b1);
        rst = 1'b0;

        // Scanner stays quiet without enable or without channels
        ch_mask = 8'hFF; en = 1'b0;
        quiet_window("quiet_en0");
        ch_mask = 8'h00; en = 1'b1;
        quiet_window("quiet_mask0");

        // Directed bursts, then back-to-back random ones
        start_burst(8'h05, 1'b0);
        finish_burst(8'h05, 8'hFF, 1'b0);
        start_burst(8'h80, 1'b1);
        finish_burst(8'h80, 8'h3C, 1'b0);
        for (int it = 0; it < 8; it++) begin
            m = 8'($urandom_range(1, 255));
            start_burst(m, 1'b1);
            finish_burst(m, 8'($urandom), it == 7);
        end
        quiet_window("no_burst_after_en_drop");

        // Host request while idle, colliding with a scan request
        host_ss_n = 1'b0;
        lat = 0;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        en = 1'b1; ch_mask = 8'hFF;
        while (!host_grant && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("grant_latency_ok", (lat >= 2) && (lat <= 3), 1'b1);
        check("host_over_scan_busy", busy, 1'b0);
        for (int k = 0; k < 6; k++) begin
            host_sclk = ~host_sclk;
            host_mosi = 1'($urandom);
            #1;
            check("mux_sclk", adc_sclk, host_sclk);
            check("mux_mosi", adc_mosi, host_mosi);
            check("mux_ss_n", adc_ss_n, 1'b0);
            check("host_miso", host_miso, adc_miso);
            @(negedge clk);
        end
        host_sclk = 1'b1;
        repeat (10) @(negedge clk);
        check("host_busy", busy, 1'b0);
        host_ss_n = 1'b1;
        lat = 0;
        while (host_grant && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("grant_release", host_grant, 1'b0);
        start_burst(8'hFF, 1'b0);
        finish_burst(8'hFF, 8'h01, 1'b1);
        repeat (30) @(negedge clk);

        // Host request during a burst waits for the gap to expire
        m = 8'($urandom_range(1, 255));
        start_burst(m, 1'b0);
        host_ss_n = 1'b0;
        en        = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (15) @(negedge clk);
            check("mid_miso_z", host_miso === 1'bz, 1'b1);
            check("mid_grant", host_grant, 1'b0);
            check("mid_ss_n", adc_ss_n, 1'b0);
        end
        wait_busy(1'b0, "busy_fall_host");
        compare_burst(m);
        lat = 0;
        while (!host_grant && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("grant_after_gap", host_grant, 1'b1);
        check("grant_wait_ok", (cyc - rise_cyc) >= SCAN_GAP, 1'b1);
        host_ss_n = 1'b1;
        lat = 0;
        while (host_grant && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("grant_release2", host_grant, 1'b0);

        // Reset in the middle of frame 1
        start_burst(8'h0F, 1'b0);
        lat = 0;
        while ((din_log.size() - din_base) < 1 && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        check("frame0_done", din_log.size() - din_base, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ss_n", adc_ss_n, 1'b1);
        check("midrst_sclk", adc_sclk, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_no_smp", smp_q.size() - smp_base, 0);
        rst = 1'b0;
        start_burst(8'h0F, 1'b0);
        finish_burst(8'h0F, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
